// File: rtl/load_store_unit_if.sv
// Data-memory request bus: req/gnt for the address phase, rvalid/rdata for the read return.
interface load_store_unit_if #(
  parameter int unsigned ADDR_W = 8
) ();
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wdata;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [31:0]       mem_rdata;

  // Initiator side (the LSU)
  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  // Memory side
  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: turns pipeline load/store ops into word-addressed memory requests,
// stalls EX while a request is in flight and returns extended load data to WB.
module load_store_unit #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  input  logic [1:0]  ex_size,
  input  logic        ex_unsigned,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_wdata,
  output logic        lsu_stall,
  output logic        wb_valid,
  output logic [31:0] wb_load_data,
  output logic [31:0] wb_alu_data,
  output logic        misalign_err,
  load_store_unit_if.master mem
);

  typedef enum logic [1:0] {StIdle, StReq, StWaitR} state_e;

  state_e            state_q, state_d;
  logic [31:0]       op_addr_q, op_addr_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] maddr_q, maddr_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       mwdata_q, mwdata_d;
  logic              wb_valid_q, wb_valid_d;
  logic              misalign_q, misalign_d;
  logic [31:0]       wb_load_q, wb_load_d;
  logic [31:0]       wb_alu_q, wb_alu_d;

  logic        is_mem, is_byte, is_half, misaligned;
  logic [3:0]  ex_be;
  logic [31:0] ex_wrep;
  logic [31:0] lane, load_ext;

  // Decode the incoming EX op: alignment, byte enables and lane-replicated store data.
  always_comb begin
    is_mem     = ex_mem_read | ex_mem_write;
    is_byte    = (ex_size == 2'b00);
    is_half    = (ex_size == 2'b01);
    misaligned = (is_half && ex_addr[0]) ||
                 (!is_byte && !is_half && (ex_addr[1:0] != 2'b00));
    if (is_byte) begin
      ex_be   = 4'b0001 << ex_addr[1:0];
      ex_wrep = {4{ex_wdata[7:0]}};
    end else if (is_half) begin
      ex_be   = ex_addr[1] ? 4'b1100 : 4'b0011;
      ex_wrep = {2{ex_wdata[15:0]}};
    end else begin
      ex_be   = 4'b1111;
      ex_wrep = ex_wdata;
    end
  end

  // Shift the addressed lane down and extend to 32 bits.
  always_comb begin
    lane = mem.mem_rdata >> {op_addr_q[1:0], 3'b000};
    unique case (size_q)
      2'b00:   load_ext = {{24{~uns_q & lane[7]}}, lane[7:0]};
      2'b01:   load_ext = {{16{~uns_q & lane[15]}}, lane[15:0]};
      default: load_ext = lane;
    endcase
  end

  // Next-state logic for the request FSM and the registered WB outputs.
  always_comb begin
    state_d    = state_q;
    op_addr_d  = op_addr_q;
    size_d     = size_q;
    uns_d      = uns_q;
    we_d       = we_q;
    maddr_d    = maddr_q;
    be_d       = be_q;
    mwdata_d   = mwdata_q;
    wb_valid_d = 1'b0;
    misalign_d = 1'b0;
    wb_load_d  = wb_load_q;
    wb_alu_d   = wb_alu_q;
    unique case (state_q)
      StIdle: begin
        if (ex_valid) begin
          if (!is_mem || misaligned) begin
            // Completes without touching memory.
            wb_valid_d = 1'b1;
            misalign_d = is_mem;
            wb_alu_d   = ex_addr;
          end else begin
            state_d   = StReq;
            op_addr_d = ex_addr;
            size_d    = ex_size;
            uns_d     = ex_unsigned;
            we_d      = ex_mem_write;
            maddr_d   = ex_addr[ADDR_W+1:2];
            be_d      = ex_be;
            mwdata_d  = ex_wrep;
          end
        end
      end
      StReq: begin
        if (mem.mem_gnt) begin
          if (we_q) begin
            state_d    = StIdle;
            wb_valid_d = 1'b1;
            wb_alu_d   = op_addr_q;
          end else begin
            state_d = StWaitR;
          end
        end
      end
      StWaitR: begin
        if (mem.mem_rvalid) begin
          state_d    = StIdle;
          wb_valid_d = 1'b1;
          wb_alu_d   = op_addr_q;
          wb_load_d  = load_ext;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers; synchronous reset abandons any op in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      op_addr_q  <= '0;
      size_q     <= '0;
      uns_q      <= 1'b0;
      we_q       <= 1'b0;
      maddr_q    <= '0;
      be_q       <= '0;
      mwdata_q   <= '0;
      wb_valid_q <= 1'b0;
      misalign_q <= 1'b0;
      wb_load_q  <= '0;
      wb_alu_q   <= '0;
    end else begin
      state_q    <= state_d;
      op_addr_q  <= op_addr_d;
      size_q     <= size_d;
      uns_q      <= uns_d;
      we_q       <= we_d;
      maddr_q    <= maddr_d;
      be_q       <= be_d;
      mwdata_q   <= mwdata_d;
      wb_valid_q <= wb_valid_d;
      misalign_q <= misalign_d;
      wb_load_q  <= wb_load_d;
      wb_alu_q   <= wb_alu_d;
    end
  end

  assign lsu_stall     = (state_q != StIdle);
  assign wb_valid      = wb_valid_q;
  assign misalign_err  = misalign_q;
  assign wb_load_data  = wb_load_q;
  assign wb_alu_data   = wb_alu_q;
  assign mem.mem_req   = (state_q == StReq);
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = maddr_q;
  assign mem.mem_be    = be_q;
  assign mem.mem_wdata = mwdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus randomized ops with random
// grant/rvalid delays, checked against a byte-lane reference model.
module tb_load_store_unit;
  localparam int unsigned ADDR_W = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_mem_read, ex_mem_write, ex_unsigned;
  logic [1:0]  ex_size;
  logic [31:0] ex_addr, ex_wdata;
  logic        lsu_stall, wb_valid, misalign_err;
  logic [31:0] wb_load_data, wb_alu_data;

  int n_checks = 0;
  int n_fail   = 0;

  load_store_unit_if #(.ADDR_W(ADDR_W)) mem_bus ();

  load_store_unit #(.ADDR_W(ADDR_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .ex_valid    (ex_valid),
    .ex_mem_read (ex_mem_read),
    .ex_mem_write(ex_mem_write),
    .ex_size     (ex_size),
    .ex_unsigned (ex_unsigned),
    .ex_addr     (ex_addr),
    .ex_wdata    (ex_wdata),
    .lsu_stall   (lsu_stall),
    .wb_valid    (wb_valid),
    .wb_load_data(wb_load_data),
    .wb_alu_data (wb_alu_data),
    .misalign_err(misalign_err),
    .mem         (mem_bus)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  function automatic bit m_misaligned(input logic [1:0] sz, input logic [31:0] a);
    return (int'(a[1:0]) % nbytes(sz)) != 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [31:0] a);
    logic [3:0] r = '0;
    int off = int'(a[1:0]);
    for (int i = 0; i < 4; i++) r[i] = (i >= off) && (i < off + nbytes(sz));
    return r;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] wd);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % nbytes(sz)) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] rd, input logic [31:0] a,
                                         input logic [1:0] sz, input logic uns);
    longint v, full;
    int bits = 8 * nbytes(sz);
    full = longint'(64'd1) << bits;
    v = (longint'(rd) >> (8 * int'(a[1:0]))) & (full - 1);
    if (!uns && v >= full / 2) v = v - full;
    return v[31:0];
  endfunction

  // ---------------- stimulus helpers (no checking) ----------------
  int                o_cyc, o_req, o_stall;
  logic              o_we, o_mis, o_tout, o_stable;
  logic [ADDR_W-1:0] o_addr;
  logic [3:0]        o_be;
  logic [31:0]       o_wdata, o_load, o_alu;

  task automatic do_reset();
    rst = 1'b1;
    ex_valid = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0; ex_size = 2'b00;
    ex_unsigned = 1'b0; ex_addr = '0; ex_wdata = '0;
    mem_bus.mem_gnt = 1'b0; mem_bus.mem_rvalid = 1'b0; mem_bus.mem_rdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Presents one op at a negedge, plays the memory with the given delays and records what the
  // DUT did until wb_valid. Returns at the negedge of the wb_valid cycle.
  task automatic run_op(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd, input int gdel,
                        input int rdel, input logic [31:0] rdat);
    int  w = 0;
    bit  granted = 0;
    o_cyc = 0; o_req = 0; o_stall = 0; o_tout = 1'b1; o_stable = 1'b1;
    o_we = 1'b0; o_addr = '0; o_be = '0; o_wdata = '0; o_load = '0; o_alu = '0; o_mis = 1'b0;
    ex_valid = 1'b1; ex_mem_read = rd; ex_mem_write = wr; ex_size = sz; ex_unsigned = uns;
    ex_addr = a; ex_wdata = wd;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk);
      @(negedge clk);
      ex_valid = 1'b0;
      o_cyc = c;
      mem_bus.mem_gnt = 1'b0;
      mem_bus.mem_rvalid = 1'b0;
      mem_bus.mem_rdata = $urandom();
      if (lsu_stall) o_stall++;
      if (wb_valid) begin
        o_load = wb_load_data; o_alu = wb_alu_data; o_mis = misalign_err; o_tout = 1'b0;
        break;
      end
      if (mem_bus.mem_req) begin
        if (o_req == 0) begin
          o_we = mem_bus.mem_we; o_addr = mem_bus.mem_addr;
          o_be = mem_bus.mem_be; o_wdata = mem_bus.mem_wdata;
        end else if (o_we !== mem_bus.mem_we || o_addr !== mem_bus.mem_addr ||
                     o_be !== mem_bus.mem_be || o_wdata !== mem_bus.mem_wdata) begin
          o_stable = 1'b0;
        end
        o_req++;
        if (o_req > gdel) begin
          mem_bus.mem_gnt = 1'b1;
          granted = 1;
        end
      end else if (lsu_stall && granted) begin
        w++;
        if (w > rdel) begin
          mem_bus.mem_rvalid = 1'b1;
          mem_bus.mem_rdata = rdat;
        end
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({lsu_stall, wb_valid, misalign_err, mem_bus.mem_req, mem_bus.mem_we} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b want 00000", {lsu_stall, wb_valid, misalign_err,
               mem_bus.mem_req, mem_bus.mem_we});
    end
    n_checks++;
    if (wb_load_data !== 32'h0 || wb_alu_data !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_wb: got %h/%h want 0/0", wb_load_data, wb_alu_data);
    end
    n_checks++;
    if (mem_bus.mem_addr !== '0 || mem_bus.mem_be !== 4'h0 || mem_bus.mem_wdata !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_bus: got %h/%h/%h want 0", mem_bus.mem_addr, mem_bus.mem_be,
               mem_bus.mem_wdata);
    end
  endtask

  task automatic test_word_store();
    run_op(1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 2, 0, 32'h0);
    n_checks++;
    if (o_tout !== 1'b0 || o_cyc !== 4) begin
      n_fail++; $display("FAIL wstore_lat: got %0d (timeout %b) want 4", o_cyc, o_tout);
    end
    n_checks++;
    if (o_req !== 3 || o_stable !== 1'b1) begin
      n_fail++; $display("FAIL wstore_req: got %0d stable %b want 3 stable 1", o_req, o_stable);
    end
    n_checks++;
    if (o_addr !== 8'd4 || o_be !== 4'b1111 || o_we !== 1'b1 || o_wdata !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL wstore_bus: got a=%h be=%b we=%b d=%h want 04 1111 1 deadbeef", o_addr, o_be,
               o_we, o_wdata);
    end
    n_checks++;
    if (o_alu !== 32'h10 || o_mis !== 1'b0) begin
      n_fail++; $display("FAIL wstore_wb: got alu=%h mis=%b want 10 0", o_alu, o_mis);
    end
    @(posedge clk); @(negedge clk);
    n_checks++;
    if (wb_valid !== 1'b0) begin
      n_fail++; $display("FAIL wstore_pulse: got wb_valid %b want 0", wb_valid);
    end
  endtask

  task automatic test_byte_load();
    run_op(1'b1, 1'b0, 2'b00, 1'b0, 32'h07, 32'h0, 0, 0, 32'h80FF1234);
    n_checks++;
    if (o_be !== 4'b1000 || o_we !== 1'b0 || o_cyc !== 3) begin
      n_fail++; $display("FAIL bload_bus: got be=%b we=%b cyc=%0d want 1000 0 3", o_be, o_we, o_cyc);
    end
    n_checks++;
    if (o_load !== 32'hFFFFFF80) begin
      n_fail++; $display("FAIL bload_signed: got %h want ffffff80", o_load);
    end
    run_op(1'b1, 1'b0, 2'b00, 1'b1, 32'h07, 32'h0, 1, 2, 32'h80FF1234);
    n_checks++;
    if (o_load !== 32'h00000080 || o_cyc !== 6) begin
      n_fail++; $display("FAIL bload_unsigned: got %h cyc=%0d want 00000080 6", o_load, o_cyc);
    end
  endtask

  task automatic test_half();
    run_op(1'b0, 1'b1, 2'b01, 1'b0, 32'h06, 32'h0000ABCD, 0, 0, 32'h0);
    n_checks++;
    if (o_be !== 4'b1100 || o_wdata !== 32'hABCDABCD || o_cyc !== 2) begin
      n_fail++;
      $display("FAIL hstore: got be=%b d=%h cyc=%0d want 1100 abcdabcd 2", o_be, o_wdata, o_cyc);
    end
    run_op(1'b1, 1'b0, 2'b01, 1'b0, 32'h06, 32'h0, 0, 1, 32'hABCD0000);
    n_checks++;
    if (o_load !== 32'hFFFFABCD || o_alu !== 32'h06) begin
      n_fail++; $display("FAIL hload: got %h alu=%h want ffffabcd 06", o_load, o_alu);
    end
  endtask

  task automatic test_misaligned();
    run_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h0A, 32'h0, 0, 0, 32'h0);
    n_checks++;
    if (o_req !== 0 || o_stall !== 0 || o_cyc !== 1) begin
      n_fail++;
      $display("FAIL misalign_flow: got req=%0d stall=%0d cyc=%0d want 0 0 1", o_req, o_stall, o_cyc);
    end
    n_checks++;
    if (o_mis !== 1'b1 || o_alu !== 32'h0A) begin
      n_fail++; $display("FAIL misalign_err: got %b alu=%h want 1 0a", o_mis, o_alu);
    end
    @(posedge clk); @(negedge clk);
    n_checks++;
    if (wb_valid !== 1'b0 || misalign_err !== 1'b0) begin
      n_fail++; $display("FAIL misalign_pulse: got %b%b want 00", wb_valid, misalign_err);
    end
  endtask

  task automatic test_back_to_back();
    ex_valid = 1'b1; ex_mem_read = 1'b0; ex_mem_write = 1'b0; ex_size = 2'b10;
    ex_unsigned = 1'b0; ex_addr = 32'h1234; ex_wdata = '0;
    @(posedge clk); @(negedge clk);
    n_checks++;
    if (wb_valid !== 1'b1 || wb_alu_data !== 32'h1234 || lsu_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_pass: got v=%b alu=%h stall=%b want 1 1234 0", wb_valid, wb_alu_data,
               lsu_stall);
    end
    ex_mem_read = 1'b1; ex_addr = 32'h20;
    @(posedge clk); @(negedge clk);
    n_checks++;
    if (lsu_stall !== 1'b1 || mem_bus.mem_req !== 1'b1 || wb_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_req: got stall=%b req=%b v=%b want 1 1 0", lsu_stall, mem_bus.mem_req,
               wb_valid);
    end
    ex_mem_read = 1'b0; ex_addr = 32'h5678;
    mem_bus.mem_gnt = 1'b1;
    @(posedge clk); @(negedge clk);
    mem_bus.mem_gnt = 1'b0;
    n_checks++;
    if (lsu_stall !== 1'b1 || mem_bus.mem_req !== 1'b0 || wb_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_wait: got stall=%b req=%b v=%b want 1 0 0", lsu_stall, mem_bus.mem_req,
               wb_valid);
    end
    mem_bus.mem_rvalid = 1'b1; mem_bus.mem_rdata = 32'hCAFEF00D;
    @(posedge clk); @(negedge clk);
    mem_bus.mem_rvalid = 1'b0;
    n_checks++;
    if (wb_valid !== 1'b1 || wb_load_data !== 32'hCAFEF00D || wb_alu_data !== 32'h20) begin
      n_fail++;
      $display("FAIL b2b_load: got v=%b d=%h alu=%h want 1 cafef00d 20", wb_valid, wb_load_data,
               wb_alu_data);
    end
    @(posedge clk); @(negedge clk);
    ex_valid = 1'b0;
    n_checks++;
    if (wb_valid !== 1'b1 || wb_alu_data !== 32'h5678 || wb_load_data !== 32'hCAFEF00D) begin
      n_fail++;
      $display("FAIL b2b_held: got v=%b alu=%h d=%h want 1 5678 cafef00d", wb_valid, wb_alu_data,
               wb_load_data);
    end
  endtask

  task automatic test_reset_mid();
    ex_valid = 1'b1; ex_mem_read = 1'b1; ex_mem_write = 1'b0; ex_size = 2'b10; ex_addr = 32'h40;
    @(posedge clk); @(negedge clk);
    ex_valid = 1'b0; ex_mem_read = 1'b0;
    mem_bus.mem_gnt = 1'b1;
    @(posedge clk); @(negedge clk);
    mem_bus.mem_gnt = 1'b0;
    n_checks++;
    if (lsu_stall !== 1'b1 || mem_bus.mem_req !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_wait: got stall=%b req=%b want 1 0", lsu_stall, mem_bus.mem_req);
    end
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    mem_bus.mem_rvalid = 1'b1; mem_bus.mem_rdata = 32'h12345678;
    @(posedge clk); @(negedge clk);
    mem_bus.mem_rvalid = 1'b0;
    n_checks++;
    if ({lsu_stall, wb_valid, misalign_err, mem_bus.mem_req, mem_bus.mem_we} !== 5'b0 ||
        wb_load_data !== 32'h0 || wb_alu_data !== 32'h0 || mem_bus.mem_be !== 4'h0 ||
        mem_bus.mem_addr !== '0 || mem_bus.mem_wdata !== 32'h0) begin
      n_fail++;
      $display("FAIL rstmid_outs: got ctl=%b d=%h alu=%h be=%b want all 0", {lsu_stall, wb_valid,
               misalign_err, mem_bus.mem_req, mem_bus.mem_we}, wb_load_data, wb_alu_data,
               mem_bus.mem_be);
    end
    @(posedge clk); @(negedge clk);
    n_checks++;
    if (wb_valid !== 1'b0 || lsu_stall !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_late: got v=%b stall=%b want 0 0", wb_valid, lsu_stall);
    end
  endtask

  task automatic test_random();
    logic [31:0] last_load = 32'h0;
    do_reset();
    for (int k = 0; k < 150; k++) begin
      int          kind, gdel, rdel, exp_cyc;
      logic        rd, wr, uns, is_mem, mem_ok, is_load;
      logic [1:0]  sz;
      logic [31:0] a, wd, rdat, exp_load;
      kind = $urandom_range(0, 3);
      rd = (kind == 1) || (kind == 3);
      wr = (kind == 2) || (kind == 3);
      sz = 2'($urandom_range(0, 3));
      uns = 1'($urandom_range(0, 1));
      a = $urandom(); wd = $urandom(); rdat = $urandom();
      gdel = $urandom_range(0, 3); rdel = $urandom_range(0, 3);
      is_mem  = rd | wr;
      mem_ok  = is_mem && !m_misaligned(sz, a);
      is_load = mem_ok && !wr;
      exp_cyc = !mem_ok ? 1 : wr ? 2 + gdel : 3 + gdel + rdel;
      exp_load = is_load ? m_load(rdat, a, sz, uns) : last_load;
      run_op(rd, wr, sz, uns, a, wd, gdel, rdel, rdat);
      n_checks++;
      if (o_tout !== 1'b0 || o_cyc !== exp_cyc) begin
        n_fail++;
        $display("FAIL rand[%0d] latency: got %0d (timeout %b) want %0d", k, o_cyc, o_tout, exp_cyc);
      end
      n_checks++;
      if (o_mis !== (is_mem && !mem_ok) || o_alu !== a) begin
        n_fail++;
        $display("FAIL rand[%0d] wb: got mis=%b alu=%h want %b %h", k, o_mis, o_alu,
                 is_mem && !mem_ok, a);
      end
      n_checks++;
      if (o_load !== exp_load) begin
        n_fail++; $display("FAIL rand[%0d] load: got %h want %h", k, o_load, exp_load);
      end
      n_checks++;
      if (o_req !== (mem_ok ? gdel + 1 : 0) || o_stall !== (mem_ok ? exp_cyc - 1 : 0)) begin
        n_fail++;
        $display("FAIL rand[%0d] req/stall: got %0d/%0d want %0d/%0d", k, o_req, o_stall,
                 mem_ok ? gdel + 1 : 0, mem_ok ? exp_cyc - 1 : 0);
      end
      if (mem_ok) begin
        n_checks++;
        if (o_addr !== a[ADDR_W+1:2] || o_be !== m_be(sz, a) || o_we !== wr || o_stable !== 1'b1 ||
            (wr && o_wdata !== m_wdata(sz, wd))) begin
          n_fail++;
          $display("FAIL rand[%0d] bus: got a=%h be=%b we=%b d=%h st=%b want %h %b %b %h 1", k,
                   o_addr, o_be, o_we, o_wdata, o_stable, a[ADDR_W+1:2], m_be(sz, a), wr,
                   m_wdata(sz, wd));
        end
      end
      last_load = exp_load;
    end
  endtask

  initial begin
    test_reset();
    test_word_store();
    test_byte_load();
    test_half();
    test_misaligned();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
